// File: rtl/reproductor_notas.sv
// Tone player: latches a note code on a play strobe, drives a square wave at that
// note's pitch for a fixed duration, then holds a silent gap and pulses completion.
module reproductor_notas #(
  parameter int unsigned DIV_DO     = 95557,
  parameter int unsigned DIV_RE     = 85131,
  parameter int unsigned DIV_MI     = 75843,
  parameter int unsigned DIV_FA     = 71586,
  parameter int unsigned DIV_SOL    = 63776,
  parameter int unsigned DIV_LA     = 56818,
  parameter int unsigned DIV_SI     = 50619,
  parameter int unsigned DUR_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] notaEntrada,
  input  logic       tocar,
  input  logic       detener,
  output logic       parlante,
  output logic       ocupado,
  output logic       notaTerminada,
  output logic [2:0] notaActual
);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  state_e      state_q;
  logic [2:0]  note_q;
  logic [31:0] dur_cnt_q;   // cycles spent in the current PLAY or GAP phase
  logic [31:0] half_cnt_q;  // cycles since the last parlante toggle
  logic        parlante_q;
  logic        ocupado_q;
  logic        terminada_q;
  logic [2:0]  nota_act_q;
  logic [31:0] half_max;

  // Terminal value of the half-period counter for the latched note.
  always_comb begin
    half_max = 32'd0;
    unique case (note_q)
      3'd1:    half_max = DIV_DO - 1;
      3'd2:    half_max = DIV_RE - 1;
      3'd3:    half_max = DIV_MI - 1;
      3'd4:    half_max = DIV_FA - 1;
      3'd5:    half_max = DIV_SOL - 1;
      3'd6:    half_max = DIV_LA - 1;
      3'd7:    half_max = DIV_SI - 1;
      default: half_max = 32'd0;
    endcase
  end

  // Control FSM with registered outputs; priority reset > detener > tocar > expiry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      note_q      <= 3'd0;
      dur_cnt_q   <= 32'd0;
      half_cnt_q  <= 32'd0;
      parlante_q  <= 1'b0;
      ocupado_q   <= 1'b0;
      terminada_q <= 1'b0;
      nota_act_q  <= 3'd0;
    end else begin
      terminada_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tocar && !detener) begin
            state_q    <= StPlay;
            note_q     <= notaEntrada;
            dur_cnt_q  <= 32'd0;
            half_cnt_q <= 32'd0;
            parlante_q <= 1'b0;
            ocupado_q  <= 1'b1;
            nota_act_q <= notaEntrada;
          end
        end
        StPlay: begin
          if (detener) begin
            state_q    <= StIdle;
            parlante_q <= 1'b0;
            ocupado_q  <= 1'b0;
            nota_act_q <= 3'd0;
          end else if (dur_cnt_q == DUR_CYCLES - 1) begin
            // Silence the buzzer at the phase change whatever its current level.
            state_q    <= StGap;
            dur_cnt_q  <= 32'd0;
            half_cnt_q <= 32'd0;
            parlante_q <= 1'b0;
            nota_act_q <= 3'd0;
          end else begin
            dur_cnt_q <= dur_cnt_q + 32'd1;
            // A rest keeps the buzzer low for the whole phase.
            if (note_q != 3'd0) begin
              if (half_cnt_q == half_max) begin
                half_cnt_q <= 32'd0;
                parlante_q <= ~parlante_q;
              end else begin
                half_cnt_q <= half_cnt_q + 32'd1;
              end
            end
          end
        end
        StGap: begin
          if (detener) begin
            state_q   <= StIdle;
            ocupado_q <= 1'b0;
          end else if (dur_cnt_q == GAP_CYCLES - 1) begin
            state_q     <= StIdle;
            dur_cnt_q   <= 32'd0;
            ocupado_q   <= 1'b0;
            terminada_q <= 1'b1;
          end else begin
            dur_cnt_q <= dur_cnt_q + 32'd1;
          end
        end
        default: begin
          state_q    <= StIdle;
          parlante_q <= 1'b0;
          ocupado_q  <= 1'b0;
          nota_act_q <= 3'd0;
        end
      endcase
    end
  end

  assign parlante      = parlante_q;
  assign ocupado       = ocupado_q;
  assign notaTerminada = terminada_q;
  assign notaActual    = nota_act_q;

endmodule

// File: tb/tb_reproductor_notas.sv
// Bench for reproductor_notas: directed and random stimulus, a timing model of a note
// (elapsed cycles since PLAY entry) and a scoreboard checked every cycle.
module tb_reproductor_notas;

  localparam int unsigned DUR = 40;
  localparam int unsigned GAP = 8;

  logic       clk;
  logic       reset;
  logic [2:0] notaEntrada;
  logic       tocar;
  logic       detener;
  logic       parlante;
  logic       ocupado;
  logic       notaTerminada;
  logic [2:0] notaActual;

  reproductor_notas #(
    .DIV_DO    (2),
    .DIV_RE    (3),
    .DIV_MI    (4),
    .DIV_FA    (5),
    .DIV_SOL   (6),
    .DIV_LA    (7),
    .DIV_SI    (8),
    .DUR_CYCLES(DUR),
    .GAP_CYCLES(GAP)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .notaEntrada  (notaEntrada),
    .tocar        (tocar),
    .detener      (detener),
    .parlante     (parlante),
    .ocupado      (ocupado),
    .notaTerminada(notaTerminada),
    .notaActual   (notaActual)
  );

  typedef struct packed {
    int unsigned tag;
    logic        parl;
    logic        ocup;
    logic        term;
    logic [2:0]  act;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  int unsigned edge_cnt = 0;
  int          n_vec    = 0;
  int          n_bad    = 0;

  // Reference model: a note is "active" for DUR+GAP cycles counted from PLAY entry.
  bit         m_active = 0;
  int         m_k      = 0;
  logic [2:0] m_note   = 3'd0;
  bit         m_term   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compare the DUT outputs with the expectation queued for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].tag == edge_cnt) begin
      cur = exp_q.pop_front();
      n_vec++;
      if (parlante !== cur.parl || ocupado !== cur.ocup || notaTerminada !== cur.term ||
          notaActual !== cur.act) begin
        n_bad++;
        $display("FAIL outputs at edge %0d: got parlante=%0b ocupado=%0b notaTerminada=%0b notaActual=%0d, expected parlante=%0b ocupado=%0b notaTerminada=%0b notaActual=%0d",
                 edge_cnt, parlante, ocupado, notaTerminada, notaActual,
                 cur.parl, cur.ocup, cur.term, cur.act);
      end
    end
  end

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic t, input logic d, input logic [2:0] n);
    if (r) begin
      m_active = 0;
      m_k      = 0;
      m_note   = 3'd0;
      m_term   = 0;
    end else if (m_active) begin
      m_term = 0;
      if (d) begin
        m_active = 0;
      end else begin
        m_k++;
        if (m_k == int'(DUR + GAP)) begin
          m_active = 0;
          m_term   = 1;
        end
      end
    end else begin
      m_term = 0;
      if (t && !d) begin
        m_active = 1;
        m_k      = 0;
        m_note   = n;
      end
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r, input logic t, input logic d, input logic [2:0] n);
    exp_t e;
    int   div;
    @(posedge clk);
    #1;
    reset       = r;
    tocar       = t;
    detener     = d;
    notaEntrada = n;
    model_edge(r, t, d, n);
    e.tag  = edge_cnt + 1;
    e.term = m_term;
    e.parl = 1'b0;
    e.ocup = 1'b0;
    e.act  = 3'd0;
    if (m_active) begin
      e.ocup = 1'b1;
      if (m_k < int'(DUR)) begin
        div    = int'(m_note) + 1;
        e.act  = m_note;
        e.parl = (m_note != 3'd0) && (((m_k / div) % 2) == 1);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 3'($urandom_range(0, 7)));
  endtask

  initial begin
    reset       = 1'b1;
    tocar       = 1'b1;
    detener     = 1'b0;
    notaEntrada = 3'd0;

    // Reset held with tocar asserted, then released with tocar low.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 3'd4);
    idle(4);

    // Single note, code 3.
    step(1'b0, 1'b1, 1'b0, 3'd3);
    idle(55);

    // Rest, then back-to-back code 7 in the completion cycle.
    step(1'b0, 1'b1, 1'b0, 3'd0);
    idle(48);
    step(1'b0, 1'b1, 1'b0, 3'd7);
    idle(60);

    // tocar while busy is ignored.
    step(1'b0, 1'b1, 1'b0, 3'd2);
    idle(10);
    step(1'b0, 1'b1, 1'b0, 3'd5);
    idle(50);

    // Abort in PLAY, then in GAP.
    step(1'b0, 1'b1, 1'b0, 3'd4);
    idle(9);
    step(1'b0, 1'b0, 1'b1, 3'd0);
    idle(60);
    step(1'b0, 1'b1, 1'b0, 3'd6);
    idle(43);
    step(1'b0, 1'b0, 1'b1, 3'd0);
    idle(60);

    // tocar and detener together in IDLE; reset during GAP.
    step(1'b0, 1'b1, 1'b1, 3'd5);
    idle(5);
    step(1'b0, 1'b1, 1'b0, 3'd1);
    idle(44);
    step(1'b1, 1'b0, 1'b0, 3'd0);
    idle(60);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 149) == 0), 3'($urandom_range(0, 7)));
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
